// File: rtl/uart_frame_ctrl_pkg.sv
// Shared types and constants for the UART frame controller: FSM states, error codes,
// the write-command payload and an index-width helper.
package uart_frame_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ERR_W  = 2;

  localparam logic [BYTE_W-1:0] DEFAULT_SYNC_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  typedef enum logic [ERR_W-1:0] {
    ERR_BAD_LEN = 2'd0,
    ERR_BAD_CHK = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

  typedef struct packed {
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } wr_cmd_t;

  // Index width for a storage of 'depth' entries, never below one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write port, asynchronous read port.
// Storage is deliberately unreset; contents are only read after being written in the same frame.
module uart_frame_buf
  import uart_frame_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [BYTE_W-1:0] rdata_c
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata_c = mem[ridx];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frames the UART receive byte stream (SYNC, ADDR, LEN, payload, CHK) into a burst of
// register writes, released only once the checksum has verified.
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter int unsigned       CLK_FREQ    = 100000000,
  parameter int unsigned       MAX_LEN     = 8,
  parameter int unsigned       TIMEOUT_CYC = 2000000,
  parameter logic [BYTE_W-1:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_done,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              wr_en,
  output logic [BYTE_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [ERR_W-1:0]  err_code
);

  localparam int unsigned BUF_IW = idx_width(MAX_LEN);
  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC);

  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BYTE_W-1:0] LEN_LIM = BYTE_W'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 16 || TIMEOUT_CYC < 2 || CLK_FREQ == 0) begin : g_bad_params
    $error("uart_frame_ctrl: unsupported parameter set");
  end

  state_t            state_q, state_d;
  logic              rx_done_q;
  logic [BYTE_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  wr_cmd_t           wr_cmd_q, wr_cmd_d;
  logic              wr_en_d, busy_d, frame_ok_d, frame_err_d;
  logic [ERR_W-1:0]  err_code_d;

  logic              stb_c;
  logic              active_c;
  logic              timed_out_c;
  logic              buf_we_c;
  logic [BUF_IW-1:0] buf_ridx_c;
  logic [BYTE_W-1:0] buf_rdata_c;

  // A byte is new only on the rising edge of the done level.
  assign stb_c       = rx_done & ~rx_done_q;
  assign active_c    = (state_q != ST_IDLE) && (state_q != ST_COMMIT);
  assign timed_out_c = active_c && !stb_c && (tcnt_q == TO_LAST);
  assign buf_ridx_c  = (state_q == ST_COMMIT) ? BUF_IW'(idx_q) : '0;

  assign wr_addr = wr_cmd_q.addr;
  assign wr_data = wr_cmd_q.data;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .IDX_W (BUF_IW)
  ) u_buf (
    .clk     (clk),
    .we      (buf_we_c),
    .widx    (BUF_IW'(idx_q)),
    .wdata   (rx_data),
    .ridx    (buf_ridx_c),
    .rdata_c (buf_rdata_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    tcnt_d      = '0;
    wr_cmd_d    = wr_cmd_q;
    wr_en_d     = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code;
    buf_we_c    = 1'b0;

    if (active_c && !stb_c) begin
      tcnt_d = tcnt_q + TO_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (stb_c && (rx_data == SYNC_BYTE)) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (stb_c) begin
          addr_d  = rx_data;
          sum_d   = rx_data;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (stb_c) begin
          if ((rx_data == '0) || (rx_data > LEN_LIM)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_BAD_LEN;
            state_d     = ST_IDLE;
          end else begin
            len_d   = CNT_W'(rx_data);
            sum_d   = sum_q + rx_data;
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (stb_c) begin
          buf_we_c = 1'b1;
          sum_d    = sum_q + rx_data;
          idx_d    = idx_q + CNT_W'(1);
          if (idx_q == len_q - CNT_W'(1)) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (stb_c) begin
          if (rx_data == sum_q) begin
            // First write issues straight from the checksum byte so the burst has no lead-in gap.
            wr_en_d       = 1'b1;
            wr_cmd_d.addr = addr_q;
            wr_cmd_d.data = buf_rdata_c;
            idx_d         = CNT_W'(1);
            state_d       = ST_COMMIT;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_BAD_CHK;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        if (idx_q == len_q) begin
          frame_ok_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          wr_en_d       = 1'b1;
          wr_cmd_d.addr = addr_q + BYTE_W'(idx_q);
          wr_cmd_d.data = buf_rdata_c;
          idx_d         = idx_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (timed_out_c) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rx_done_q <= 1'b1;
      addr_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      tcnt_q    <= '0;
      wr_cmd_q  <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
    end else begin
      state_q   <= state_d;
      rx_done_q <= rx_done;
      addr_q    <= addr_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      tcnt_q    <= tcnt_d;
      wr_cmd_q  <= wr_cmd_d;
      wr_en     <= wr_en_d;
      busy      <= busy_d;
      frame_ok  <= frame_ok_d;
      frame_err <= frame_err_d;
      err_code  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames plus a randomized stream,
// scored against a byte-stream parser model of the frame rules.
module tb_uart_frame_ctrl;

  localparam int unsigned MAX_LEN     = 8;
  localparam int unsigned TIMEOUT_CYC = 300;
  localparam logic [7:0]  SYNC        = 8'hAA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b1;
  logic [7:0] rx_data = 8'hAA;
  logic       wr_en, busy, frame_ok, frame_err;
  logic [7:0] wr_addr, wr_data;
  logic [1:0] err_code;

  uart_frame_ctrl #(
    .CLK_FREQ    (100000000),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int raise_cyc = 0;
  int err_cyc   = 0;
  int both_hi   = 0;

  logic [15:0] got_wr[$];
  int          got_ok;
  int          got_err[$];
  logic [15:0] exp_wr[$];
  int          exp_ok;
  int          exp_err[$];
  logic [7:0]  stream[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) got_wr.push_back({wr_addr, wr_data});
    if (frame_ok) got_ok++;
    if (frame_err) begin
      got_err.push_back(int'(err_code));
      err_cyc = cyc;
    end
    if (frame_ok && frame_err) both_hi++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: parse the byte stream using the frame rules directly.
  task automatic model(input logic [7:0] s[$]);
    int i = 0;
    int len;
    int sum;
    logic [7:0] addr;
    exp_wr.delete();
    exp_err.delete();
    exp_ok = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 2 >= s.size()) break;
      addr = s[i+1];
      len  = int'(s[i+2]);
      if (len == 0 || len > MAX_LEN) begin
        exp_err.push_back(0);
        i += 3;
        continue;
      end
      if (i + 3 + len >= s.size()) break;
      sum = int'(addr) + len;
      for (int k = 0; k < len; k++) sum += int'(s[i+3+k]);
      if (s[i+3+len] == 8'(sum % 256)) begin
        for (int k = 0; k < len; k++) exp_wr.push_back({8'((int'(addr) + k) % 256), s[i+3+k]});
        exp_ok++;
      end else begin
        exp_err.push_back(1);
      end
      i += 4 + len;
    end
  endtask

  function automatic logic [7:0] chk_of(input logic [7:0] a, input int len, input logic [7:0] p[$]);
    int sum = int'(a) + len;
    foreach (p[k]) sum += int'(p[k]);
    return 8'(sum % 256);
  endfunction

  task automatic add_frame(input logic [7:0] a, input int len, input bit corrupt);
    logic [7:0] p[$];
    logic [7:0] c;
    for (int k = 0; k < len; k++) p.push_back(8'($urandom_range(0, 255)));
    c = chk_of(a, len, p);
    if (corrupt) c = c ^ 8'($urandom_range(1, 255));
    stream.push_back(SYNC);
    stream.push_back(a);
    stream.push_back(8'(len));
    foreach (p[k]) stream.push_back(p[k]);
    stream.push_back(c);
  endtask

  task automatic clear_all();
    got_wr.delete();
    got_err.delete();
    got_ok = 0;
    stream.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b0;
    repeat ($urandom_range(2, 5)) @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    raise_cyc = cyc;
    repeat ($urandom_range(12, 20)) @(negedge clk);
  endtask

  task automatic play();
    foreach (stream[k]) send_byte(stream[k]);
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_done = 1'b1;
    rx_data = SYNC;
    clear_all();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({wr_en, busy, frame_ok, frame_err, err_code, wr_addr, wr_data} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 0", {wr_en, busy, frame_ok, frame_err, err_code, wr_addr, wr_data});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || got_err.size() != 0) begin
      n_fail++;
      $display("FAIL reset_no_spurious_stb busy %b errs %0d exp busy 0 errs 0", busy, got_err.size());
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] p[$];
    logic [7:0] c;
    clear_all();
    p = '{8'h5A, 8'hA5};
    c = chk_of(8'h10, 2, p);
    send_byte(SYNC);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL good_busy got %b exp 1", busy);
    end
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'h5A);
    send_byte(8'hA5);
    @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    rx_data = c;
    rx_done = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h10, 8'h5A}) begin
      n_fail++;
      $display("FAIL good_first_write got %h exp %h", {wr_en, wr_addr, wr_data}, {1'b1, 8'h10, 8'h5A});
    end
    @(negedge clk);
    n_tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h11, 8'hA5}) begin
      n_fail++;
      $display("FAIL good_second_write got %h exp %h", {wr_en, wr_addr, wr_data}, {1'b1, 8'h11, 8'hA5});
    end
    @(negedge clk);
    n_tests++;
    if ({wr_en, frame_ok, frame_err} !== 3'b010) begin
      n_fail++;
      $display("FAIL good_frame_ok got %b exp 010", {wr_en, frame_ok, frame_err});
    end
    @(negedge clk);
    n_tests++;
    if ({frame_ok, busy} !== 2'b00 || got_err.size() != 0) begin
      n_fail++;
      $display("FAIL good_after got ok %b busy %b errs %0d exp 0 0 0", frame_ok, busy, got_err.size());
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_errors();
    logic [7:0] p[$];
    clear_all();
    stream = '{SYNC, 8'h10, 8'h02, 8'h5A, 8'hA5, 8'h00, SYNC, 8'h10, 8'h00, SYNC, 8'h10, 8'h09};
    add_frame(8'h30, 1, 1'b0);
    add_frame(8'h05, MAX_LEN, 1'b0);
    model(stream);
    play();
    n_tests++;
    if (got_wr.size() != exp_wr.size()) begin
      n_fail++;
      $display("FAIL err_wr_count got %0d exp %0d", got_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[k]) if (k < got_wr.size()) begin
      n_tests++;
      if (got_wr[k] !== exp_wr[k]) begin
        n_fail++;
        $display("FAIL err_wr[%0d] got %h exp %h", k, got_wr[k], exp_wr[k]);
      end
    end
    n_tests++;
    if (got_ok != exp_ok) begin
      n_fail++;
      $display("FAIL err_ok_count got %0d exp %0d", got_ok, exp_ok);
    end
    n_tests++;
    if (got_err.size() != exp_err.size()) begin
      n_fail++;
      $display("FAIL err_err_count got %0d exp %0d", got_err.size(), exp_err.size());
    end
    foreach (exp_err[k]) if (k < got_err.size()) begin
      n_tests++;
      if (got_err[k] != exp_err[k]) begin
        n_fail++;
        $display("FAIL err_code[%0d] got %0d exp %0d", k, got_err[k], exp_err[k]);
      end
    end
    // Last error was BAD_LEN and must persist across the following good frames.
    n_tests++;
    if (err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL err_code_held got %0d exp 0", err_code);
    end
  endtask

  task automatic test_timeout();
    int delta;
    clear_all();
    send_byte(SYNC);
    send_byte(8'h20);
    for (int w = 0; w < int'(TIMEOUT_CYC) + 50 && got_err.size() == 0; w++) @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (got_err.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_count got %0d exp 1", got_err.size());
    end else if (got_err[0] != 2) begin
      n_fail++;
      $display("FAIL timeout_code got %0d exp 2", got_err[0]);
    end
    delta = err_cyc - raise_cyc;
    n_tests++;
    if (delta < int'(TIMEOUT_CYC) || delta > int'(TIMEOUT_CYC) + 2) begin
      n_fail++;
      $display("FAIL timeout_delay got %0d exp %0d..%0d", delta, TIMEOUT_CYC, TIMEOUT_CYC + 2);
    end
    n_tests++;
    if (busy !== 1'b0 || got_wr.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_idle busy %b writes %0d exp 0 0", busy, got_wr.size());
    end
    // Gaps just under the limit must not time out.
    clear_all();
    add_frame(8'h40, 2, 1'b0);
    model(stream);
    foreach (stream[k]) begin
      @(negedge clk);
      rx_done = 1'b0;
      repeat (TIMEOUT_CYC - 40) @(negedge clk);
      rx_data = stream[k];
      rx_done = 1'b1;
      repeat (5) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (got_ok != 1 || got_err.size() != 0 || got_wr.size() != 2) begin
      n_fail++;
      $display("FAIL slow_frame got ok %0d errs %0d writes %0d exp 1 0 2", got_ok, got_err.size(), got_wr.size());
    end else if (got_wr[1] !== exp_wr[1]) begin
      n_fail++;
      $display("FAIL slow_frame_data got %h exp %h", got_wr[1], exp_wr[1]);
    end
  endtask

  task automatic test_wrap_garbage();
    clear_all();
    stream = '{8'h55, 8'h00, SYNC, 8'hFF, 8'h02, SYNC, 8'h01, 8'hAC};
    model(stream);
    play();
    n_tests++;
    if (got_wr.size() != exp_wr.size() || got_ok != exp_ok || got_err.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_counts got wr %0d ok %0d err %0d exp %0d %0d 0", got_wr.size(), got_ok, got_err.size(), exp_wr.size(), exp_ok);
    end
    foreach (exp_wr[k]) if (k < got_wr.size()) begin
      n_tests++;
      if (got_wr[k] !== exp_wr[k]) begin
        n_fail++;
        $display("FAIL wrap_wr[%0d] got %h exp %h", k, got_wr[k], exp_wr[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_all();
    send_byte(SYNC);
    send_byte(8'h10);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, err_code} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_state got busy %b code %0d exp 0 0", busy, err_code);
    end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_tests++;
    if (got_wr.size() != 0 || got_ok != 0 || got_err.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_quiet got wr %0d ok %0d err %0d busy %b exp 0 0 0 0", got_wr.size(), got_ok, got_err.size(), busy);
    end
    clear_all();
    add_frame(8'h10, 3, 1'b0);
    model(stream);
    play();
    n_tests++;
    if (got_ok != 1 || got_wr.size() != 3) begin
      n_fail++;
      $display("FAIL midreset_fresh got ok %0d writes %0d exp 1 3", got_ok, got_wr.size());
    end else if (got_wr[2] !== exp_wr[2]) begin
      n_fail++;
      $display("FAIL midreset_fresh_data got %h exp %h", got_wr[2], exp_wr[2]);
    end
  endtask

  task automatic test_back_to_back();
    int kind;
    logic [7:0] g;
    clear_all();
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom_range(0, 255));
        if (g == SYNC) g = 8'h00;
        stream.push_back(g);
      end
      kind = $urandom_range(0, 99);
      if (kind < 70) begin
        add_frame(8'($urandom_range(0, 255)), $urandom_range(1, MAX_LEN), 1'b0);
      end else if (kind < 85) begin
        add_frame(8'($urandom_range(0, 255)), $urandom_range(1, MAX_LEN), 1'b1);
      end else begin
        stream.push_back(SYNC);
        stream.push_back(8'($urandom_range(0, 255)));
        stream.push_back((kind < 90) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end
    end
    model(stream);
    play();
    n_tests++;
    if (got_wr.size() != exp_wr.size()) begin
      n_fail++;
      $display("FAIL rand_wr_count got %0d exp %0d", got_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[k]) if (k < got_wr.size()) begin
      n_tests++;
      if (got_wr[k] !== exp_wr[k]) begin
        n_fail++;
        $display("FAIL rand_wr[%0d] got %h exp %h", k, got_wr[k], exp_wr[k]);
      end
    end
    n_tests++;
    if (got_ok != exp_ok) begin
      n_fail++;
      $display("FAIL rand_ok_count got %0d exp %0d", got_ok, exp_ok);
    end
    n_tests++;
    if (got_err.size() != exp_err.size()) begin
      n_fail++;
      $display("FAIL rand_err_count got %0d exp %0d", got_err.size(), exp_err.size());
    end
    foreach (exp_err[k]) if (k < got_err.size()) begin
      n_tests++;
      if (got_err[k] != exp_err[k]) begin
        n_fail++;
        $display("FAIL rand_err[%0d] got %0d exp %0d", k, got_err[k], exp_err[k]);
      end
    end
    n_tests++;
    if (both_hi != 0) begin
      n_fail++;
      $display("FAIL ok_err_overlap got %0d cycles exp 0", both_hi);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_errors();
    test_timeout();
    test_wrap_garbage();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
